mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//  Load/store controller for the MEM stage of the 16-bit CPU. It sits directly upstream of datamemory.
//  - Accepts one execute-stage request per handshake.
//  - Sequences datamemory's address, datawrite, memread, memwrite and memtoreg controls over MEM_LAT wait cycles.
//  - Bounds-checks the address.
//  - Holds the result for writeback under a valid/ready handshake.
// PARAMETERS
//  DATA_W     16  data width (ALU result, store data, load data)
//  ADDR_W     16  address width
//  REG_W      3   destination register index width
//  MEM_DEPTH  16  number of valid data-memory words; legal addresses are 0..MEM_DEPTH-1
//  MEM_LAT    1   cycles the memory controls are held per access; must be >= 1
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       asynchronous reset, active-high
//  ex_valid     in   1       execute stage presents a request
//  ex_ready     out  1       LSU accepts the request this cycle
//  ex_memread   in   1       request is a load
//  ex_memwrite  in   1       request is a store
//  ex_regwrite  in   1       result is written to the register file
//  ex_rd        in   REG_W   destination register
//  ex_addr      in   ADDR_W  ALU result; this is the memory address for loads and stores
//  ex_wdata     in   DATA_W  store data
//  mem_address  out  ADDR_W  connects to datamemory address
//  mem_wdata    out  DATA_W  connects to datamemory datawrite
//  mem_read     out  1       connects to datamemory memread
//  mem_write    out  1       connects to datamemory memwrite
//  mem_memtoreg out  1       connects to datamemory memtoreg; 1 only during load access
//  mem_rdata    in   DATA_W  connects to datamemory readdata
//  wb_valid     out  1       writeback result valid
//  wb_ready     in   1       writeback stage consumes the result
//  wb_regwrite  out  1       register-file write enable for the result
//  wb_rd        out  REG_W   destination register
//  wb_data      out  DATA_W  load data or passed-through ALU result
//  wb_fault     out  1       request faulted; no memory side effect occurred
// BEHAVIOUR
//  Reset (async, rst=1):
//   - state=IDLE; all registered outputs 0 (mem_*, wb_*); latency counter 0.
//   - ex_ready=1 while in IDLE, but no request is latched while rst=1.
//  ex_ready is combinational: ex_ready = (state==IDLE) | (state==RESP & wb_ready).
//  A request is accepted when ex_valid & ex_ready. Its fields are latched on that edge.
//  Request classes at accept:
//   - FAULT: ex_memread & ex_memwrite both 1, or (either is 1 and ex_addr >= MEM_DEPTH).
//     -> go to RESP next cycle; wb_fault=1, wb_regwrite=0, wb_data=0.
//     -> mem_read and mem_write are never asserted for this request.
//   - PASS (neither memread nor memwrite): go to RESP next cycle; wb_data=ex_addr; wb_regwrite=ex_regwrite.
//   - LOAD: go to ACCESS for MEM_LAT cycles.
//     -> mem_address and mem_memtoreg=1 are held throughout; mem_read=1 is held throughout.
//     -> mem_rdata is sampled on the final ACCESS edge into wb_data, then go to RESP.
//   - STORE: go to ACCESS for MEM_LAT cycles.
//     -> mem_address and mem_wdata are held throughout; mem_memtoreg=0.
//     -> mem_write=1 only in the final ACCESS cycle (exactly one cycle).
//     -> In RESP: wb_regwrite=0, wb_data=0.
//  ACCESS uses a down-counter loaded with MEM_LAT-1 at accept; ACCESS exits when the count reaches 0.
//  Latency, accept to wb_valid: PASS/FAULT 1 cycle; LOAD/STORE MEM_LAT+1 cycles.
//  RESP:
//   - wb_valid=1, and wb_* stay stable until wb_ready=1.
//   - wb_ready=1 with no new accept -> IDLE, wb_valid=0.
//   - wb_ready=1 with a simultaneous new accept -> next request starts with no bubble.
//     For PASS/FAULT the state stays RESP, and new data appears on the next cycle.
//  Outside ACCESS: mem_read=0, mem_write=0, mem_memtoreg=0. mem_address holds its last value.
//  rst asserted mid-ACCESS:
//   - The request is dropped and mem_write deasserts immediately.
//   - A store whose final cycle has not been reached never writes.
//  Widths: the address compare is unsigned on ADDR_W bits; no arithmetic is performed on data.
// STRUCTURE
//  lsu_pkg (shared header) holds:
//   - state encodings IDLE=2'd0, ACCESS=2'd1, RESP=2'd2;
//   - request class encodings PASS/LOAD/STORE/FAULT.
//  Both the CPU top and the bench reuse lsu_pkg.
//  One sub-module: lsu_lat_counter.
//   - Loadable down-counter of width $clog2(MEM_LAT+1) with a done output.
//   - Everything else is a single FSM plus output registers in mem_stage_lsu.
// TESTING
//  T1 reset: rst=1 mid-store ACCESS with MEM_LAT=3 -> mem_write never pulses; all wb_* are 0; mem word unchanged.
//  T2 store then load: store addr 5 data 16'hBEEF, then load addr 5 rd 3.
//     -> mem_write high exactly 1 cycle.
//     -> load gives wb_data=16'hBEEF, wb_rd=3, wb_regwrite=1, wb_valid at accept+MEM_LAT+1.
//  T3 pass-through: addr=16'h1234, rd=2, regwrite=1 -> next cycle wb_data=16'h1234, wb_regwrite=1, mem_read=mem_write=0.
//  T4 faults:
//     - load addr 16 (MEM_DEPTH=16) -> wb_fault=1, wb_regwrite=0, no mem_read.
//     - memread&memwrite at addr 2 -> wb_fault=1, mem word 2 unchanged.
//  T5 backpressure: wb_ready=0 for 4 cycles in RESP -> wb_* stable and ex_ready=0; wb_ready=1 -> exactly one consume.
//  T6 back-to-back: 3 PASS requests with ex_valid and wb_ready held 1 -> wb_valid high 3 consecutive cycles, in order.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit.
// Holds FSM states, request classes and the classifier.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } lsu_state_e;

   typedef enum logic [1:0] {
      PASS  = 2'd0,
      LOAD  = 2'd1,
      STORE = 2'd2,
      FAULT = 2'd3
   } lsu_cls_e;

   localparam int LSU_DATA_W    = 16;
   localparam int LSU_ADDR_W    = 16;
   localparam int LSU_REG_W     = 3;
   localparam int LSU_MEM_DEPTH = 16;

   // oob: address outside the data memory
   function automatic lsu_cls_e lsu_classify(
      input logic rd,
      input logic wr,
      input logic oob
   );
      lsu_cls_e c;
      if (rd && wr)
         c = FAULT;
      else if ((rd || wr) && oob)
         c = FAULT;
      else if (rd)
         c = LOAD;
      else if (wr)
         c = STORE;
      else
         c = PASS;
      return c;
   endfunction

endpackage

// File: rtl/lsu_lat_counter.sv
// Loadable down-counter timing the memory access window.
// Ports: load_i reloads MEM_LAT-1, dec_i counts down, done_o at 0.
module lsu_lat_counter #(
   parameter int MEM_LAT = 1,
   parameter int CW      = $clog2(MEM_LAT + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   input  logic dec_i,
   output logic done_o
);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = CW'(MEM_LAT - 1);
      else if (dec_i && (cnt_q != '0))
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store controller in front of datamemory.
// Ports: ex_* request handshake, mem_* datamemory controls,
// wb_* writeback result handshake with fault flag.
module mem_stage_lsu
   import lsu_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 16,
   parameter int REG_W     = 3,
   parameter int MEM_DEPTH = 16,
   parameter int MEM_LAT   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic              ex_memread,
   input  logic              ex_memwrite,
   input  logic              ex_regwrite,
   input  logic [REG_W-1:0]  ex_rd,
   input  logic [ADDR_W-1:0] ex_addr,
   input  logic [DATA_W-1:0] ex_wdata,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic              mem_memtoreg,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic              wb_regwrite,
   output logic [REG_W-1:0]  wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_fault
);

   lsu_state_e state_q, state_d;
   logic is_load_q, is_load_d;
   logic is_store_q, is_store_d;
   logic [ADDR_W-1:0] mem_address_q, mem_address_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic wb_regwrite_q, wb_regwrite_d;
   logic [REG_W-1:0] wb_rd_q, wb_rd_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic wb_fault_q, wb_fault_d;

   logic accept, oob, in_access, cnt_done, cnt_load;
   lsu_cls_e cls;

   assign in_access = (state_q == ACCESS);
   assign ex_ready  = (state_q == IDLE)
                    | ((state_q == RESP) & wb_ready);
   assign accept    = ex_valid & ex_ready;
   assign oob       = (ex_addr >= ADDR_W'(MEM_DEPTH));
   assign cls       = lsu_classify(ex_memread, ex_memwrite, oob);
   assign cnt_load  = accept & ((cls == LOAD) | (cls == STORE));

   lsu_lat_counter #(
      .MEM_LAT (MEM_LAT)
   ) u_lat (
      .clk    (clk),
      .rst    (rst),
      .load_i (cnt_load),
      .dec_i  (in_access),
      .done_o (cnt_done)
   );

   always_comb begin
      state_d       = state_q;
      is_load_d     = is_load_q;
      is_store_d    = is_store_q;
      mem_address_d = mem_address_q;
      mem_wdata_d   = mem_wdata_q;
      wb_regwrite_d = wb_regwrite_q;
      wb_rd_d       = wb_rd_q;
      wb_data_d     = wb_data_q;
      wb_fault_d    = wb_fault_q;

      unique case (state_q)
         IDLE: ;
         ACCESS: begin
            if (cnt_done) begin
               state_d    = RESP;
               is_load_d  = 1'b0;
               is_store_d = 1'b0;
               wb_fault_d = 1'b0;
               wb_data_d  = is_load_q ? mem_rdata : '0;
            end
         end
         RESP: begin
            if (wb_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // An accept in RESP overrides the drop to IDLE (no bubble).
      if (accept) begin
         wb_rd_d    = ex_rd;
         wb_fault_d = 1'b0;
         wb_data_d  = '0;
         is_load_d  = 1'b0;
         is_store_d = 1'b0;
         unique case (cls)
            PASS: begin
               state_d       = RESP;
               wb_regwrite_d = ex_regwrite;
               wb_data_d     = DATA_W'(ex_addr);
            end
            FAULT: begin
               state_d       = RESP;
               wb_regwrite_d = 1'b0;
               wb_fault_d    = 1'b1;
            end
            LOAD: begin
               state_d       = ACCESS;
               is_load_d     = 1'b1;
               mem_address_d = ex_addr;
               wb_regwrite_d = ex_regwrite;
            end
            STORE: begin
               state_d       = ACCESS;
               is_store_d    = 1'b1;
               mem_address_d = ex_addr;
               mem_wdata_d   = ex_wdata;
               wb_regwrite_d = 1'b0;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         is_load_q     <= 1'b0;
         is_store_q    <= 1'b0;
         mem_address_q <= '0;
         mem_wdata_q   <= '0;
         wb_regwrite_q <= 1'b0;
         wb_rd_q       <= '0;
         wb_data_q     <= '0;
         wb_fault_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         is_load_q     <= is_load_d;
         is_store_q    <= is_store_d;
         mem_address_q <= mem_address_d;
         mem_wdata_q   <= mem_wdata_d;
         wb_regwrite_q <= wb_regwrite_d;
         wb_rd_q       <= wb_rd_d;
         wb_data_q     <= wb_data_d;
         wb_fault_q    <= wb_fault_d;
      end
   end

   // Strobes decode from reset-cleared state, so rst drops them at once.
   assign mem_read     = in_access & is_load_q;
   assign mem_memtoreg = in_access & is_load_q;
   assign mem_write    = in_access & is_store_q & cnt_done;
   assign mem_address  = mem_address_q;
   assign mem_wdata    = mem_wdata_q;
   assign wb_valid     = (state_q == RESP);
   assign wb_regwrite  = wb_regwrite_q;
   assign wb_rd        = wb_rd_q;
   assign wb_data      = wb_data_q;
   assign wb_fault     = wb_fault_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu with a 16-word data memory.
// Runs with MEM_LAT=3 so access timing is visible.
module tb_mem_stage_lsu;
   import lsu_pkg::*;

   localparam int LAT = 3;

   typedef struct {
      logic        regwrite;
      logic [2:0]  rd;
      logic [15:0] data;
      logic        fault;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic ex_valid, ex_ready, ex_memread, ex_memwrite, ex_regwrite;
   logic [2:0] ex_rd;
   logic [15:0] ex_addr, ex_wdata;
   logic [15:0] mem_address, mem_wdata, mem_rdata;
   logic mem_read, mem_write, mem_memtoreg;
   logic wb_valid, wb_ready, wb_regwrite, wb_fault;
   logic [2:0] wb_rd;
   logic [15:0] wb_data;

   logic [15:0] dmem [16];
   logic init_en;
   int wr_cnt = 0;
   int rd_cnt = 0;
   int tests = 0;
   int fails = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   mem_stage_lsu #(
      .DATA_W(LSU_DATA_W), .ADDR_W(LSU_ADDR_W), .REG_W(LSU_REG_W),
      .MEM_DEPTH(LSU_MEM_DEPTH), .MEM_LAT(LAT)
   ) dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
      .ex_regwrite(ex_regwrite), .ex_rd(ex_rd),
      .ex_addr(ex_addr), .ex_wdata(ex_wdata),
      .mem_address(mem_address), .mem_wdata(mem_wdata),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_memtoreg(mem_memtoreg), .mem_rdata(mem_rdata),
      .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
      .wb_data(wb_data), .wb_fault(wb_fault)
   );

   always @(posedge clk) begin
      if (init_en) begin
         for (int i = 0; i < 16; i++)
            dmem[i] <= 16'hA000 | 16'(i);
      end else if (mem_write && mem_address < 16'd16) begin
         dmem[mem_address[3:0]] <= mem_wdata;
      end
      if (mem_write) wr_cnt <= wr_cnt + 1;
      if (mem_read)  rd_cnt <= rd_cnt + 1;
   end

   assign mem_rdata = mem_read ? dmem[mem_address[3:0]] : 16'h0;

   // Drives one request, waits for wb_valid; lat counts edges.
   task automatic send_wait(
      input logic mr, input logic mw, input logic rw,
      input logic [2:0] dst, input logic [15:0] a,
      input logic [15:0] d, input exp_t e, output int lat
   );
      ex_valid = 1'b1; ex_memread = mr; ex_memwrite = mw;
      ex_regwrite = rw; ex_rd = dst; ex_addr = a; ex_wdata = d;
      sb.push_back(e);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         ex_valid = 1'b0;
      end while (!wb_valid && lat < 20);
   endtask

   task automatic test_reset();
      rst = 1'b1; init_en = 1'b1; wb_ready = 1'b1;
      ex_valid = 1'b1; ex_memread = 1'b0; ex_memwrite = 1'b0;
      ex_regwrite = 1'b1; ex_rd = 3'd7; ex_addr = 16'h7777;
      ex_wdata = 16'h0;
      @(negedge clk);
      init_en = 1'b0;
      tests++;
      if (ex_ready !== 1'b1) begin
         fails++; $display("FAIL rst_ex_ready: got %b want 1", ex_ready);
      end
      tests++;
      if ({wb_valid, wb_regwrite, wb_fault, wb_rd, wb_data} !== 22'h0) begin
         fails++; $display("FAIL rst_wb: got v%b d%h want 0", wb_valid, wb_data);
      end
      tests++;
      if ({mem_read, mem_write, mem_memtoreg, mem_address} !== 19'h0) begin
         fails++; $display("FAIL rst_mem: got r%b w%b a%h want 0",
                           mem_read, mem_write, mem_address);
      end
      ex_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      tests++;
      if (wb_valid !== 1'b0) begin
         fails++; $display("FAIL rst_no_latch: got %b want 0", wb_valid);
      end
   endtask

   task automatic test_reset_mid_store();
      int w0;
      w0 = wr_cnt;
      ex_valid = 1'b1; ex_memread = 1'b0; ex_memwrite = 1'b1;
      ex_regwrite = 1'b0; ex_rd = 3'd5; ex_addr = 16'd7;
      ex_wdata = 16'h5555;
      @(negedge clk);
      ex_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      tests++;
      if ({mem_read, mem_write, mem_memtoreg} !== 3'b000) begin
         fails++; $display("FAIL midrst_strobes: got %b want 000",
                           {mem_read, mem_write, mem_memtoreg});
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      tests++;
      if (wr_cnt - w0 !== 0) begin
         fails++; $display("FAIL midrst_write: got %0d want 0", wr_cnt - w0);
      end
      tests++;
      if (dmem[7] !== 16'hA007) begin
         fails++; $display("FAIL midrst_mem: got %h want a007", dmem[7]);
      end
      tests++;
      if ({wb_valid, wb_regwrite, wb_fault, wb_rd, wb_data} !== 22'h0) begin
         fails++; $display("FAIL midrst_wb: got rd%h d%h want 0", wb_rd, wb_data);
      end
   endtask

   task automatic test_store_load();
      exp_t e, g;
      int lat, w0, r0;
      w0 = wr_cnt;
      e = '{regwrite: 1'b0, rd: 3'd1, data: 16'h0, fault: 1'b0};
      send_wait(1'b0, 1'b1, 1'b1, 3'd1, 16'd5, 16'hBEEF, e, lat);
      g = sb.pop_front();
      tests++;
      if (lat !== LAT + 1) begin
         fails++; $display("FAIL st_latency: got %0d want %0d", lat, LAT + 1);
      end
      tests++;
      if ({wb_regwrite, wb_data, wb_fault} !== {g.regwrite, g.data, g.fault}) begin
         fails++; $display("FAIL st_wb: got w%b d%h want w%b d%h",
                           wb_regwrite, wb_data, g.regwrite, g.data);
      end
      tests++;
      if (wr_cnt - w0 !== 1) begin
         fails++; $display("FAIL st_pulses: got %0d want 1", wr_cnt - w0);
      end
      tests++;
      if (dmem[5] !== 16'hBEEF) begin
         fails++; $display("FAIL st_mem: got %h want beef", dmem[5]);
      end
      @(negedge clk);
      r0 = rd_cnt;
      e = '{regwrite: 1'b1, rd: 3'd3, data: 16'hBEEF, fault: 1'b0};
      send_wait(1'b1, 1'b0, 1'b1, 3'd3, 16'd5, 16'h0, e, lat);
      g = sb.pop_front();
      tests++;
      if (lat !== LAT + 1) begin
         fails++; $display("FAIL ld_latency: got %0d want %0d", lat, LAT + 1);
      end
      tests++;
      if ({wb_regwrite, wb_rd, wb_data, wb_fault} !==
          {g.regwrite, g.rd, g.data, g.fault}) begin
         fails++; $display("FAIL ld_wb: got w%b rd%0d d%h want w%b rd%0d d%h",
                           wb_regwrite, wb_rd, wb_data, g.regwrite, g.rd, g.data);
      end
      tests++;
      if (rd_cnt - r0 !== LAT) begin
         fails++; $display("FAIL ld_read_cycles: got %0d want %0d", rd_cnt - r0, LAT);
      end
      @(negedge clk);
   endtask

   task automatic test_pass();
      exp_t e, g;
      int lat, w0, r0;
      w0 = wr_cnt; r0 = rd_cnt;
      e = '{regwrite: 1'b1, rd: 3'd2, data: 16'h1234, fault: 1'b0};
      send_wait(1'b0, 1'b0, 1'b1, 3'd2, 16'h1234, 16'h0, e, lat);
      g = sb.pop_front();
      tests++;
      if (lat !== 1) begin
         fails++; $display("FAIL pass_latency: got %0d want 1", lat);
      end
      tests++;
      if ({wb_regwrite, wb_rd, wb_data, wb_fault} !==
          {g.regwrite, g.rd, g.data, g.fault}) begin
         fails++; $display("FAIL pass_wb: got rd%0d d%h want rd%0d d%h",
                           wb_rd, wb_data, g.rd, g.data);
      end
      tests++;
      if ((wr_cnt - w0) + (rd_cnt - r0) !== 0) begin
         fails++; $display("FAIL pass_mem_strobes: got %0d want 0",
                           (wr_cnt - w0) + (rd_cnt - r0));
      end
      @(negedge clk);
   endtask

   task automatic test_faults();
      exp_t e, g;
      int lat, w0, r0;
      r0 = rd_cnt;
      e = '{regwrite: 1'b0, rd: 3'd4, data: 16'h0, fault: 1'b1};
      send_wait(1'b1, 1'b0, 1'b1, 3'd4, 16'd16, 16'h0, e, lat);
      g = sb.pop_front();
      tests++;
      if ({lat == 1, wb_fault, wb_regwrite, wb_data} !==
          {1'b1, g.fault, g.regwrite, g.data}) begin
         fails++; $display("FAIL oob_load: got lat%0d f%b w%b d%h want lat1 f1 w0 d0",
                           lat, wb_fault, wb_regwrite, wb_data);
      end
      tests++;
      if (rd_cnt - r0 !== 0) begin
         fails++; $display("FAIL oob_read: got %0d want 0", rd_cnt - r0);
      end
      @(negedge clk);
      w0 = wr_cnt;
      e = '{regwrite: 1'b0, rd: 3'd1, data: 16'h0, fault: 1'b1};
      send_wait(1'b1, 1'b1, 1'b1, 3'd1, 16'd2, 16'hDEAD, e, lat);
      g = sb.pop_front();
      tests++;
      if ({wb_fault, wb_regwrite, wb_data} !== {g.fault, g.regwrite, g.data}) begin
         fails++; $display("FAIL rw_fault: got f%b w%b d%h want f1 w0 d0",
                           wb_fault, wb_regwrite, wb_data);
      end
      @(negedge clk);
      tests++;
      if (wr_cnt - w0 !== 0 || dmem[2] !== 16'hA002) begin
         fails++; $display("FAIL rw_mem: got w%0d m%h want w0 ma002",
                           wr_cnt - w0, dmem[2]);
      end
   endtask

   task automatic test_backpressure();
      exp_t e, g;
      int lat;
      wb_ready = 1'b0;
      e = '{regwrite: 1'b1, rd: 3'd6, data: 16'h0BAD, fault: 1'b0};
      send_wait(1'b0, 1'b0, 1'b1, 3'd6, 16'h0BAD, 16'h0, e, lat);
      g = sb.pop_front();
      for (int i = 0; i < 4; i++) begin
         tests++;
         if ({wb_valid, ex_ready, wb_rd, wb_data} !== {2'b10, g.rd, g.data}) begin
            fails++; $display("FAIL stall_%0d: got v%b r%b rd%0d d%h want v1 r0 rd%0d d%h",
                              i, wb_valid, ex_ready, wb_rd, wb_data, g.rd, g.data);
         end
         @(negedge clk);
      end
      wb_ready = 1'b1;
      @(negedge clk);
      tests++;
      if (wb_valid !== 1'b0) begin
         fails++; $display("FAIL stall_consume: got %b want 0", wb_valid);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e, g;
      wb_ready = 1'b1;
      ex_memread = 1'b0; ex_memwrite = 1'b0; ex_regwrite = 1'b1;
      ex_wdata = 16'h0;
      ex_valid = 1'b1; ex_rd = 3'd1; ex_addr = 16'h0100;
      e = '{regwrite: 1'b1, rd: 3'd1, data: 16'h0100, fault: 1'b0};
      sb.push_back(e);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (i < 2) begin
            ex_rd = 3'(i + 2);
            ex_addr = 16'h0100 + 16'(i + 1);
            e = '{regwrite: 1'b1, rd: 3'(i + 2), data: ex_addr, fault: 1'b0};
            sb.push_back(e);
         end else begin
            ex_valid = 1'b0;
         end
         g = sb.pop_front();
         tests++;
         if ({wb_valid, wb_rd, wb_data} !== {1'b1, g.rd, g.data}) begin
            fails++; $display("FAIL b2b_%0d: got v%b rd%0d d%h want v1 rd%0d d%h",
                              i, wb_valid, wb_rd, wb_data, g.rd, g.data);
         end
      end
      @(negedge clk);
      tests++;
      if (wb_valid !== 1'b0) begin
         fails++; $display("FAIL b2b_drain: got %b want 0", wb_valid);
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid_store();
      test_store_load();
      test_pass();
      test_faults();
      test_backpressure();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
